// File: rtl/classical_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : classical_mult_pkg
// Description : Shared widths, types and latency for the classical
//               (schoolbook) 32x32->64 unsigned multiplier.
//               LATENCY follows the CLASSICAL_MULT_PIPE_EN build macro.
// Revision    : 1.0  initial release
// ============================================================================
package classical_mult_pkg;

   localparam int OPW   = 32;
   localparam int PRODW = 64;

   typedef logic [OPW-1:0]   operand_t;
   typedef logic [PRODW-1:0] product_t;

`ifdef CLASSICAL_MULT_PIPE_EN
   localparam int LATENCY = 2;
`else
   localparam int LATENCY = 1;
`endif

endpackage : classical_mult_pkg
`default_nettype wire

// File: rtl/classical_pp_gen.sv
`default_nettype none
// ============================================================================
// Module      : classical_pp_gen
// Description : Combinational partial-product generator. Row i is the
//               zero-extended multiplicand shifted left by i when multiplier
//               bit i is set, otherwise zero.
// Revision    : 1.0  initial release
// ============================================================================
module classical_pp_gen
   import classical_mult_pkg::*;
(
   input  logic [OPW-1:0]            i_a,
   input  logic [OPW-1:0]            i_b,
   output logic [OPW-1:0][PRODW-1:0] o_pp
);

   product_t w_a_ext;

   assign w_a_ext = {{(PRODW-OPW){1'b0}}, i_a};

   // One shifted, gated copy of the multiplicand per multiplier bit
   for (genvar i = 0; i < OPW; i++) begin : g_pp
      assign o_pp[i] = i_b[i] ? (w_a_ext << i) : '0;
   end

endmodule : classical_pp_gen
`default_nettype wire

// File: rtl/classical_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : classical_multiplier
// Description : Unsigned 32x32->64 shift-and-add multiplier. 32 partial
//               products are reduced by a 5-level balanced adder tree
//               (16->8->4->2->1) into a registered product. Datapath
//               registers load every cycle; out_valid qualifies ans.
//               Build macro CLASSICAL_MULT_PIPE_EN inserts a register after
//               tree level 3 (latency 2 instead of 1).
// Revision    : 1.0  initial release
// ============================================================================
module classical_multiplier
   import classical_mult_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [OPW-1:0]   a,
   input  logic [OPW-1:0]   b,
   output logic             out_valid,
   output logic [PRODW-1:0] ans
);

   logic [OPW-1:0][PRODW-1:0] w_pp;
   product_t                  w_l1   [16];
   product_t                  w_l2   [8];
   product_t                  w_l3   [4];
   product_t                  w_l3_q [4];
   product_t                  w_l4   [2];
   product_t                  w_l5;
   product_t                  r_ans;
   logic [LATENCY-1:0]        r_vld;

   classical_pp_gen u_pp_gen (
      .i_a  (a),
      .i_b  (b),
      .o_pp (w_pp)
   );

   // Tree levels 1-3: 32 -> 16 -> 8 -> 4 partial sums
   for (genvar i = 0; i < 16; i++) begin : g_l1
      assign w_l1[i] = w_pp[2*i] + w_pp[2*i+1];
   end
   for (genvar i = 0; i < 8; i++) begin : g_l2
      assign w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
   end
   for (genvar i = 0; i < 4; i++) begin : g_l3
      assign w_l3[i] = w_l2[2*i] + w_l2[2*i+1];
   end

`ifdef CLASSICAL_MULT_PIPE_EN
   product_t r_l3 [4];

   // Mid-tree register stage holding the four level-3 sums
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) r_l3[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) r_l3[i] <= w_l3[i];
      end
   end

   assign w_l3_q = r_l3;

   // Two-deep valid chain matching the two datapath register stages
   always_ff @(posedge clk) begin
      if (rst) r_vld <= '0;
      else     r_vld <= {r_vld[0], in_valid};
   end
`else
   assign w_l3_q = w_l3;

   // Single-stage valid delay matching the output register
   always_ff @(posedge clk) begin
      if (rst) r_vld <= '0;
      else     r_vld <= in_valid;
   end
`endif

   // Tree levels 4-5: 4 -> 2 -> 1; carry out of bit 63 cannot occur
   for (genvar i = 0; i < 2; i++) begin : g_l4
      assign w_l4[i] = w_l3_q[2*i] + w_l3_q[2*i+1];
   end
   assign w_l5 = w_l4[0] + w_l4[1];

   // Output register loads every cycle; only reset overrides it
   always_ff @(posedge clk) begin
      if (rst) r_ans <= '0;
      else     r_ans <= w_l5;
   end

   assign ans       = r_ans;
   assign out_valid = r_vld[LATENCY-1];

endmodule : classical_multiplier
`default_nettype wire

// File: tb/tb_classical_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_classical_multiplier
// Description : Self-checking bench for classical_multiplier. Table-driven
//               vectors plus hand-written reset sequences; expected results
//               are queued at drive time and compared as outputs come due.
// Revision    : 1.0  initial release
// ============================================================================
module tb_classical_multiplier;
   import classical_mult_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic [63:0] ans;

   typedef struct {
      logic        v;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   typedef struct {
      int          due;
      int          id;
      logic        vld;
      logic [63:0] ans;
   } exp_t;

   exp_t q[$];
   vec_t tbl[11];
   int   cyc     = 0;
   int   n_total = 0;
   int   n_pass  = 0;
   int   next_id = 0;

   classical_multiplier dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .ans       (ans)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Compare every queued expectation whose output is visible this cycle
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due == cyc) begin
         exp_t e;
         e = q.pop_front();
         n_total++;
         if (out_valid === e.vld) n_pass++;
         else $display("FAIL out_valid[%0d] actual=%b required=%b", e.id, out_valid, e.vld);
         n_total++;
         if (ans === e.ans) n_pass++;
         else $display("FAIL ans[%0d] actual=%h required=%h", e.id, ans, e.ans);
      end
   end

   // Drive one cycle of stimulus and queue what it should produce
   task automatic step(input logic r, input logic v, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] exp);
      rst = r; in_valid = v; a = x; b = y;
      if (r) begin
         while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
         for (int k = 1; k <= LATENCY; k++)
            q.push_back('{due: cyc + k, id: next_id, vld: 1'b0, ans: 64'd0});
      end else begin
         q.push_back('{due: cyc + LATENCY, id: next_id, vld: v, ans: exp});
      end
      next_id++;
      @(posedge clk); #1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 32'd2,          32'd3,          64'd6};
      tbl[1]  = '{1'b1, 32'd5,          32'd7,          64'd35};
      tbl[2]  = '{1'b1, 32'd9,          32'd12,         64'd108};
      tbl[3]  = '{1'b1, 32'd14,         32'd18,         64'd252};
      tbl[4]  = '{1'b1, 32'd123123123,  32'd121212121,  64'd14924014882973883};
      tbl[5]  = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
      tbl[6]  = '{1'b1, 32'h0,          32'hFFFF_FFFF,  64'h0};
      tbl[7]  = '{1'b1, 32'h1,          32'h8000_0000,  64'h8000_0000};
      tbl[8]  = '{1'b1, 32'd3,          32'd4,          64'd12};
      tbl[9]  = '{1'b0, 32'd6,          32'd6,          64'd36};
      tbl[10] = '{1'b1, 32'd10,         32'd10,         64'd100};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
      #1;

      // Reset held two cycles with live operands, then first release
      step(1'b1, 1'b1, 32'd5, 32'd7, 64'd0);
      step(1'b1, 1'b1, 32'd5, 32'd7, 64'd0);
      step(1'b0, 1'b1, 32'd5, 32'd7, 64'd35);

      // Back-to-back table vectors, including an in_valid gap
      for (int i = 0; i < 11; i++)
         step(1'b0, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].exp);

      // Mid-stream reset with products in flight
      step(1'b0, 1'b1, 32'd100, 32'd200, 64'd20000);
      step(1'b0, 1'b1, 32'd300, 32'd400, 64'd120000);
      step(1'b1, 1'b1, 32'd7,   32'd7,   64'd0);
      step(1'b0, 1'b1, 32'd8,   32'd9,   64'd72);
      step(1'b0, 1'b0, 32'd0,   32'd0,   64'd0);

      // Drain: every queued expectation must have come due
      repeat (LATENCY + 1) @(negedge clk);
      #1;
      n_total++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain actual=%0d pending required=0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_classical_multiplier
`default_nettype wire
